// File: rtl/audio_pkg.sv
// Shared definitions for the codec audio paths (playback and capture).
// Both directions use the same sample width and slot length so that one
// frame clock period serves the DAC and the ADC alike.
package audio_pkg;

  // Sample width per channel.
  localparam int SAMPLE_W = 24;

  // Bit-clock cycles per channel half-frame. This is the default; a frame
  // is two slots long.
  localparam int DEFAULT_SLOT = 25;

  // Which half of the frame is active. The encoding matches the level of
  // the codec frame clock: 0 = left, 1 = right.
  typedef enum logic {
    SLOT_LEFT  = 1'b0,
    SLOT_RIGHT = 1'b1
  } slot_e;

endpackage : audio_pkg

// File: rtl/audio_in.sv
// Codec capture path. Generates the ADC frame clock, deserialises
// left-justified MSB-first samples from the codec data pin, and presents
// each completed left/right pair through a one-deep valid/ready register.
// Data is sampled on the falling edge of the bit clock, which is the
// rising edge of AUD_BCLK. Everything else updates on the rising edge.
module audio_in
  import audio_pkg::*;
#(
  parameter int BITS = SAMPLE_W,     // sample width per channel
  parameter int SLOT = DEFAULT_SLOT  // cycles per half-frame, >= BITS+1
) (
  input  logic            clock12500khz,
  input  logic            resetn,
  input  logic            adcdat,
  output logic            adclrck,
  output logic [BITS-1:0] left,
  output logic [BITS-1:0] right,
  output logic            sample_valid,
  input  logic            sample_ready,
  output logic            overrun
);

  // Counter width: wide enough for 0..SLOT-1.
  localparam int CW = (SLOT > 1) ? $clog2(SLOT) : 1;

  // Last cycle of a slot; the counter wraps after it.
  localparam logic [CW-1:0] C_LAST = CW'(SLOT - 1);
  // Cycle carrying the LSB; the word completes at the posedge ending it.
  localparam logic [CW-1:0] C_DONE = CW'(BITS - 1);
  // First ignored cycle; bits sampled from here to C_LAST are dropped.
  localparam logic [CW-1:0] C_BITS = CW'(BITS);

  // Slot sequencer state.
  slot_e          slot_q, slot_d;
  logic [CW-1:0]  c_q, c_d;
  // Set by reset: the sequencer sits in a right slot with a wrap pending,
  // so the first posedge after release starts left cycle 0.
  logic           wrap_q, wrap_d;

  // Data path registers.
  logic            adc_bit;      // falling-edge capture of adcdat
  logic [BITS-1:0] shift_q;      // serial-to-parallel shifter
  logic [BITS-1:0] shift_next;   // shifter contents including this bit
  logic [BITS-1:0] staging_q;    // completed left word awaiting its pair

  // Decoded strobes for the current cycle.
  logic shift_en;
  logic left_done;
  logic pair_done;
  logic accept;

  // Sample the serial data on the falling bit-clock edge, half a cycle
  // after the codec launches it, to give setup margin in both directions.
  always_ff @(negedge clock12500khz or negedge resetn) begin
    if (!resetn) begin
      adc_bit <= 1'b0;
    end else begin
      // NOTE: sequential state is always assigned with <= so every flop
      // samples pre-edge values regardless of statement order.
      adc_bit <= adcdat;
    end
  end

  // Slot sequencer state register; the frame clock is registered from the
  // next-state slot so it changes exactly when the slot does.
  always_ff @(posedge clock12500khz or negedge resetn) begin
    if (!resetn) begin
      slot_q  <= SLOT_RIGHT;
      c_q     <= '0;
      wrap_q  <= 1'b1;
      adclrck <= 1'b1;
    end else begin
      slot_q  <= slot_d;
      c_q     <= c_d;
      wrap_q  <= wrap_d;
      adclrck <= (slot_d == SLOT_RIGHT);
    end
  end

  // Slot sequencer next state: count 0..SLOT-1 and flip slots on wrap.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    slot_d = slot_q;
    c_d    = c_q;
    wrap_d = 1'b0;
    if (wrap_q) begin
      slot_d = SLOT_LEFT;
      c_d    = '0;
    end else if (c_q == C_LAST) begin
      c_d    = '0;
      slot_d = (slot_q == SLOT_LEFT) ? SLOT_RIGHT : SLOT_LEFT;
    end else begin
      c_d    = c_q + 1'b1;
    end
  end

  // Cycle decode: which data-path actions happen at the coming posedge.
  always_comb begin
    shift_en   = !wrap_q && (c_q < C_BITS);
    left_done  = !wrap_q && (slot_q == SLOT_LEFT)  && (c_q == C_DONE);
    pair_done  = !wrap_q && (slot_q == SLOT_RIGHT) && (c_q == C_DONE);
    accept     = sample_valid && sample_ready;
    shift_next = {shift_q[BITS-2:0], adc_bit};
  end

  // Shift in one data bit per cycle during the data portion of each slot.
  // Exactly BITS bits are shifted per slot, so the previous word falls out
  // without an explicit clear.
  always_ff @(posedge clock12500khz or negedge resetn) begin
    if (!resetn) begin
      shift_q <= '0;
    end else if (shift_en) begin
      shift_q <= shift_next;
    end
  end

  // Hold the completed left word until the matching right word arrives.
  always_ff @(posedge clock12500khz or negedge resetn) begin
    if (!resetn) begin
      staging_q <= '0;
    end else if (left_done) begin
      staging_q <= shift_next;
    end
  end

  // One-deep holding register with valid/ready handshake. A new pair
  // always wins; overwriting an unconsumed pair flags an overrun, while a
  // pair accepted on the same edge is not lost.
  always_ff @(posedge clock12500khz or negedge resetn) begin
    if (!resetn) begin
      left         <= '0;
      right        <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (pair_done) begin
        left         <= staging_q;
        right        <= shift_next;
        sample_valid <= 1'b1;
        overrun      <= sample_valid && !sample_ready;
      end else if (accept) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule : audio_in

// File: tb/tb_audio_in.sv
// Directed bench for audio_in: default 24/25 instance plus a 16/32 one.
module tb_audio_in;

  logic clk = 1'b0;
  always #40 clk = ~clk;

  // Default instance (BITS=24, SLOT=25).
  logic        resetn, adcdat, sample_ready;
  logic        adclrck, sample_valid, overrun;
  logic [23:0] left, right;

  // Narrow instance (BITS=16, SLOT=32).
  logic        resetn16, adcdat16, ready16;
  logic        adclrck16, valid16, overrun16;
  logic [15:0] left16, right16;

  audio_in u_dut (
    .clock12500khz (clk),
    .resetn        (resetn),
    .adcdat        (adcdat),
    .adclrck       (adclrck),
    .left          (left),
    .right         (right),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .overrun       (overrun)
  );

  audio_in #(.BITS(16), .SLOT(32)) u_dut16 (
    .clock12500khz (clk),
    .resetn        (resetn16),
    .adcdat        (adcdat16),
    .adclrck       (adclrck16),
    .left          (left16),
    .right         (right16),
    .sample_valid  (valid16),
    .sample_ready  (ready16),
    .overrun       (overrun16)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Per-cycle observations of the last frame; index k = posedges since the
  // left-slot start.
  logic        valid_log [0:64];
  logic        ovr_log   [0:64];
  logic        lrck_log  [0:64];
  logic [23:0] cap_l, cap_r;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Serialise one frame MSB-first. Called just after the posedge that
  // starts left cycle 0; returns just after the next frame's start.
  // mode: 0 = ready low, 1 = ready high, 2 = ready only for the load edge.
  task automatic run_frame(input bit sel, input logic [23:0] l, input logic [23:0] r,
                           input int mode, input bit noise);
    int slot_n, bits_n;
    slot_n = sel ? 32 : 25;
    bits_n = sel ? 16 : 24;
    for (int i = 0; i < 2 * slot_n; i++) begin
      int   c;
      logic b;
      logic rdy;
      c = i % slot_n;
      if (c < bits_n) b = (i < slot_n) ? l[bits_n-1-c] : r[bits_n-1-c];
      else            b = noise;
      case (mode)
        0:       rdy = 1'b0;
        1:       rdy = 1'b1;
        default: rdy = (i == slot_n + bits_n - 1);
      endcase
      #1;
      if (sel) begin adcdat16 = b; ready16 = rdy; end
      else     begin adcdat   = b; sample_ready = rdy; end
      @(posedge clk);
      #2;
      if (sel) begin
        valid_log[i+1] = valid16;
        ovr_log[i+1]   = overrun16;
        lrck_log[i+1]  = adclrck16;
        if (i + 1 == slot_n + bits_n) begin
          cap_l = {8'h00, left16};
          cap_r = {8'h00, right16};
        end
      end else begin
        valid_log[i+1] = sample_valid;
        ovr_log[i+1]   = overrun;
        lrck_log[i+1]  = adclrck;
        if (i + 1 == slot_n + bits_n) begin
          cap_l = left;
          cap_r = right;
        end
      end
    end
  endtask

  function automatic int first_valid(input int n);
    for (int k = 1; k <= n; k++) if (valid_log[k] === 1'b1) return k;
    return -1;
  endfunction

  function automatic int count_valid(input int n);
    int cnt = 0;
    for (int k = 1; k <= n; k++) if (valid_log[k] === 1'b1) cnt++;
    return cnt;
  endfunction

  function automatic int count_ovr(input int n);
    int cnt = 0;
    for (int k = 1; k <= n; k++) if (ovr_log[k] === 1'b1) cnt++;
    return cnt;
  endfunction

  // Frame clock must be low for cycles 0..slot-1 and high for the rest.
  task automatic check_lrck(input string tag, input int slot_n);
    int bad = 0;
    for (int k = 1; k <= 2 * slot_n; k++)
      if (lrck_log[k] !== ((k % (2 * slot_n)) >= slot_n)) bad++;
    check(tag, bad, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; adcdat = 1'b0; sample_ready = 1'b0;
    resetn16 = 1'b0; adcdat16 = 1'b0; ready16 = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    check("rst_lrck",  adclrck, 1);
    check("rst_valid", sample_valid, 0);
    check("rst_ovr",   overrun, 0);
    check("rst_left",  left, 0);
    check("rst_right", right, 0);

    // Release; first posedge starts left cycle 0.
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #2;
    check("start_lrck", adclrck, 0);

    // Frame 1: consumer always ready.
    run_frame(0, 24'hA55A3C, 24'h800001, 1, 0);
    check("f1_first_valid", first_valid(50), 49);
    check("f1_valid_cnt",   count_valid(50), 1);
    check("f1_left",  cap_l, 24'hA55A3C);
    check("f1_right", cap_r, 24'h800001);
    check("f1_ovr",   count_ovr(50), 0);
    check_lrck("f1_lrck", 25);

    // Frames 2 and 3: consumer stalled, noise on ignored bits.
    run_frame(0, 24'h000001, 24'hFFFFFF, 0, 1);
    check("f2_first_valid", first_valid(50), 49);
    check("f2_valid_cnt",   count_valid(50), 2);
    check("f2_left",  cap_l, 24'h000001);
    check("f2_right", cap_r, 24'hFFFFFF);
    check("f2_ovr",   count_ovr(50), 0);

    run_frame(0, 24'h7FFFFF, 24'h800000, 0, 1);
    check("f3_valid_cnt", count_valid(50), 50);
    check("f3_ovr_cnt",   count_ovr(50), 1);
    check("f3_ovr_at49",  ovr_log[49], 1);
    check("f3_left",  cap_l, 24'h7FFFFF);
    check("f3_right", cap_r, 24'h800000);
    check("f3_hold_left", left, 24'h7FFFFF);
    check_lrck("f3_lrck", 25);

    // Frame 4: ready exactly at the load edge.
    run_frame(0, 24'h123456, 24'h654321, 2, 1);
    check("f4_valid_cnt", count_valid(50), 50);
    check("f4_ovr_cnt",   count_ovr(50), 0);
    check("f4_left",  cap_l, 24'h123456);
    check("f4_right", cap_r, 24'h654321);

    // Consume the held pair (accepted at the posedge ending left cycle 0).
    #1 sample_ready = 1'b1;
    @(posedge clk);
    #2;
    check("consume_valid", sample_valid, 0);
    sample_ready = 1'b0;

    // Now in left cycle 1; advance to left cycle 10 and abort the frame.
    repeat (9) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    check("mid_rst_lrck",  adclrck, 1);
    check("mid_rst_valid", sample_valid, 0);
    check("mid_rst_left",  left, 0);
    repeat (3) @(posedge clk);
    #2;
    check("mid_rst_lrck_hold", adclrck, 1);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #2;
    check("restart_lrck", adclrck, 0);
    run_frame(0, 24'h0F0F0F, 24'hF0F0F0, 1, 1);
    check("f5_first_valid", first_valid(50), 49);
    check("f5_valid_cnt",   count_valid(50), 1);
    check("f5_left",  cap_l, 24'h0F0F0F);
    check("f5_right", cap_r, 24'hF0F0F0);

    // Narrow instance: 16-bit words in 32-cycle slots.
    @(negedge clk) resetn16 = 1'b1;
    @(posedge clk);
    #2;
    check("n_start_lrck", adclrck16, 0);
    run_frame(1, 24'h001234, 24'h00FEDC, 1, 1);
    check("n_first_valid", first_valid(64), 48);
    check("n_valid_cnt",   count_valid(64), 1);
    check("n_left",  cap_l, 24'h001234);
    check("n_right", cap_r, 24'h00FEDC);
    check_lrck("n_lrck", 32);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_audio_in
